// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: XLEN, ALU op codes, M-extension funct3
// encodings and the multiply/divide controller state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_COPY_B = 4'b1111;

  // RV32M funct3 encodings
  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } muldiv_state_e;

  // Operand signedness for an op: bit 1 = rs1 signed, bit 0 = rs2 signed.
  // MUL is treated as signed; its low half is identical either way.
  function automatic logic [1:0] muldiv_signed_ops(input logic [2:0] op);
    case (op)
      MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM: muldiv_signed_ops = 2'b11;
      MULDIV_MULHSU:                                   muldiv_signed_ops = 2'b10;
      default:                                         muldiv_signed_ops = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Multiply/divide datapath: product, remainder and quotient registers,
// one radix-2 shift-add or restoring-subtract step per cycle, and the
// sign-correction / result-selection logic used in the FIX state.
module muldiv_dp #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            load_div,
  input  logic            step,
  input  logic [XLEN-1:0] mag1,
  input  logic [XLEN-1:0] mag2,
  input  logic [2:0]      op,
  input  logic            neg_res,
  input  logic            neg_rem,
  input  logic            div_zero,
  output logic [XLEN-1:0] fix_result
);
  import riscv_pkg::*;

  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   opb;

  logic [XLEN:0]     add_sum;
  logic [XLEN+1:0]   sub_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // Step arithmetic: conditional add of the multiplicand into the upper
  // product half, and trial subtraction of the divisor from the shifted
  // partial remainder (the extra top bit acts as the borrow).
  always_comb begin
    add_sum  = {1'b0, prod[2*XLEN-1:XLEN]};
    if (prod[0]) begin
      add_sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opb};
    end
    sub_diff = {rem, quo[XLEN-1]} - {2'b00, opb};
  end

  // Datapath registers: loaded on accept, advanced one step per CALC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      rem  <= '0;
      quo  <= '0;
      opb  <= '0;
    end else if (load) begin
      opb  <= load_div ? mag2 : mag1;
      prod <= {{XLEN{1'b0}}, mag2};
      rem  <= '0;
      quo  <= mag1;
    end else if (step) begin
      if (op[2]) begin
        if (!sub_diff[XLEN+1]) begin
          rem <= sub_diff[XLEN:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          rem <= {rem[XLEN-1:0], quo[XLEN-1]};
          quo <= {quo[XLEN-2:0], 1'b0};
        end
      end else begin
        prod <= {add_sum, prod[XLEN-1:1]};
      end
    end
  end

  // Sign correction and selection of the architectural result.
  // A zero divisor leaves the magnitude quotient all ones, but the sign
  // fix would corrupt it, so it is forced here.
  always_comb begin
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -quo : quo;
    if (div_zero) begin
      quo_fix = '1;
    end
    rem_fix  = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    case (op)
      MULDIV_MUL:                              fix_result = prod_fix[XLEN-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      MULDIV_DIV, MULDIV_DIVU:                 fix_result = quo_fix;
      default:                                 fix_result = rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide controller: FSM, iteration counter,
// pipeline handshake and special-case detection. Optional build macro
// MULDIV_FAST_PATH_EN resolves divide-by-zero, signed overflow and
// multiply-by-zero directly from IDLE with a one-cycle latency.
module muldiv_ctrl #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import riscv_pkg::*;

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  muldiv_state_e   state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            neg_res;
  logic            neg_rem;
  logic            div_zero;

  logic [1:0]      sgn;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            op2_zero;
  logic            load;
  logic [XLEN-1:0] fix_result;

  // Operand signs and magnitudes for the incoming request
  always_comb begin
    sgn      = muldiv_signed_ops(op_i);
    neg1     = sgn[1] & op1_i[XLEN-1];
    neg2     = sgn[0] & op2_i[XLEN-1];
    mag1     = neg1 ? -op1_i : op1_i;
    mag2     = neg2 ? -op2_i : op2_i;
    op2_zero = (op2_i == '0);
  end

`ifdef MULDIV_FAST_PATH_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;

  // Results that need no iteration, bit-identical to the full loop
  always_comb begin
    fast_hit    = 1'b0;
    fast_result = '0;
    if (op_i[2]) begin
      if (op2_zero) begin
        fast_hit    = 1'b1;
        fast_result = op_i[1] ? op1_i : '1;
      end else if (!op_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1)) begin
        fast_hit    = 1'b1;
        fast_result = op_i[1] ? '0 : op1_i;
      end
    end else if ((op1_i == '0) || op2_zero) begin
      fast_hit    = 1'b1;
      fast_result = '0;
    end
  end
`endif

  assign load    = start_i & ~flush_i & ~rst_i & (state == MD_IDLE);
  assign stall_o = (start_i & ready_o & ~flush_i) | (state == MD_CALC) | (state == MD_FIX);

  // Control FSM with registered handshake outputs; flush returns to IDLE
  // without touching result_o, while a DONE pulse already registered still shows.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state   <= MD_IDLE;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_q     <= op_i;
            neg_res  <= neg1 ^ neg2;
            neg_rem  <= neg1;
            div_zero <= op_i[2] & op2_zero;
            cnt      <= CNT_LAST;
            ready_o  <= 1'b0;
`ifdef MULDIV_FAST_PATH_EN
            if (fast_hit) begin
              result_o <= fast_result;
              done_o   <= 1'b1;
              state    <= MD_DONE;
            end else begin
              state <= MD_CALC;
            end
`else
            state <= MD_CALC;
`endif
          end
        end
        MD_CALC: begin
          if (cnt == '0) begin
            state <= MD_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MD_FIX: begin
          result_o <= fix_result;
          done_o   <= 1'b1;
          state    <= MD_DONE;
        end
        MD_DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= MD_IDLE;
        end
        default: begin
          state   <= MD_IDLE;
          ready_o <= 1'b1;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

  muldiv_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (load),
    .load_div   (op_i[2]),
    .step       (state == MD_CALC),
    .mag1       (mag1),
    .mag2       (mag2),
    .op         (op_q),
    .neg_res    (neg_res),
    .neg_rem    (neg_rem),
    .div_zero   (div_zero),
    .fix_result (fix_result)
  );

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multi-cycle controller for the RV32M multiply/divide instructions.
- Sits beside the single-cycle alu in the EX stage.
- Accepts one operation from EX, stalls the pipeline while a radix-2 shift-add or restoring-divide loop runs, then returns a sign-corrected result with a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  request a new operation; accepted only while ready_o=1
op_i  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  input  XLEN  rs1 operand (multiplicand / dividend)
op2_i  input  XLEN  rs2 operand (multiplier / divisor)
flush_i  input  1  abort any in-flight operation (branch mispredict / trap)
ready_o  output  1  high in IDLE; can accept start_i
stall_o  output  1  pipeline stall request
done_o  output  1  one-cycle pulse; result_o valid
result_o  output  XLEN  final result; held until the next accepted start

Behaviour:
- Reset (rst_i=1 at an edge):
  - State goes to IDLE; the counter and all datapath registers clear.
  - Outputs after reset: ready_o=1, stall_o=0, done_o=0, result_o=0.
  - rst_i overrides every other input.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1 and flush_i=0, latch op_i and the operand magnitudes; record the result sign (neg_res) and the remainder sign.
  - Signedness of the latched magnitudes: MULH takes both operands as signed, MULHSU takes op1 signed and op2 unsigned, the U variants take both unsigned.
  - Load cnt=XLEN-1, then go to CALC.
- CALC:
  - One radix-2 step per cycle.
  - Multiply: a 2*XLEN product register, shift-add.
  - Divide: restoring; the remainder register is XLEN+1 bits.
  - At cnt==0 go to FIX; otherwise cnt decrements.
- FIX:
  - Negate the product or quotient when neg_res=1. Negate the remainder when the dividend was negative (DIV/REM only).
  - Select the output: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder. Register the selection into result_o.
  - Then go to DONE.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
- Latency: start accepted at cycle 0 → done_o high at cycle XLEN+2 (cycle 34 for XLEN=32).
- stall_o:
  - Asserted combinationally when start_i=1 and ready_o=1 and flush_i=0.
  - Asserted throughout CALC and FIX.
  - Low in DONE, so EX advances and captures result_o in the same cycle.
- start_i while not in IDLE is ignored. No queueing.
- Divide by zero:
  - Quotient = all ones for both DIV and DIVU; FIX forces this regardless of sign.
  - Remainder = dividend, unmodified.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- flush_i:
  - In any state, flush_i forces IDLE at the next edge. No done_o; result_o keeps its old value.
  - flush_i together with start_i: the flush wins and the start is not accepted.
  - flush_i during DONE: the done_o of that cycle still fires, since the pulse is already registered.
- Mid-operation reset: same as a flush, plus all outputs clear.

Optional Feature:
MULDIV_FAST_PATH_EN
- Defined:
  - Divide-by-zero, signed overflow, and multiply with either operand zero skip CALC/FIX.
  - The result is computed in IDLE and the FSM goes straight to DONE, so done_o rises at cycle 1.
  - stall_o is high only in the accept cycle.
- Undefined: every operation takes the full XLEN+2 latency, with bit-identical results.

Decomposition:
- Shared package riscv_pkg holds:
  - The MULDIV_* funct3 constants and the muldiv FSM state typedef.
  - XLEN.
  - The existing ALU_* op codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, COPY_B 1111, moved from alu.
- One sub-module, muldiv_dp: the product/remainder registers, the shift-add and restoring-subtract step, and the negation logic.
- muldiv_ctrl keeps the FSM, the counter, the handshake and the special-case detection.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD → result_o=0xFFFFFFEB; done_o exactly at cycle 34; stall_o high for cycles 0–33 and low at cycle 34.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0.
  - With MULDIV_FAST_PATH_EN, done_o arrives at cycle 1; without it, at cycle 34.
- Flush and back-to-back:
  - flush_i at cycle 10 of a DIV → no done_o, ready_o=1 at cycle 11; a new MUL 3×4 started at cycle 11 → 12 at cycle 45.
  - start_i asserted during CALC is ignored.
- rst_i asserted at cycle 5 of a MUL → at the next edge ready_o=1, result_o=0, stall_o=0, and done_o never fires.
